// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the multi-channel memory read arbiter wrapper:
//   - arbitration mode constants
//   - channel-index width helper
//   - read-return tag carried alongside the RAM read pipeline
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ARB_RR    = 0;  // round-robin
  localparam int ARB_FIXED = 1;  // fixed priority, channel 0 highest

  // Tag channel field is sized for the largest supported channel count (16).
  localparam int MAX_NCH  = 16;
  localparam int MAX_CH_W = 4;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_w(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [MAX_CH_W-1:0] ch;
  } rd_tag_t;

endpackage

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Inferred simple-dual-port RAM, one write port and one read port on a common
// clock. Read-first: a read and write to the same address in the same cycle
// returns the previous contents. Read latency is RD_LAT cycles (1 or 2); with 2
// an extra output register is added.
// Ports:
//   clk    clock for both ports
//   wea    write enable,   addra write address, dina write data
//   enb    read enable,    addrb read address
//   doutb  read data, valid RD_LAT cycles after enb
// -----------------------------------------------------------------------------
module sdp_ram #(
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  // NOTE: the array has no reset so it maps onto block RAM; resetting a memory
  // forces it into flops.
  // NOTE: non-blocking assignment here is what makes the read see the
  // pre-write contents (read-first) when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) rd_q <= mem[addrb];
  end

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk) begin
      doutb <= rd_q;
    end
  end else begin : g_lat1
    assign doutb = rd_q;
  end

endmodule

// File: rtl/mem_arb_rd_wrap.sv
// -----------------------------------------------------------------------------
// mem_arb_rd_wrap
// Puts NCH independent read channels and one write port on a single
// simple-dual-port RAM. A registered-pointer arbiter (round-robin or fixed
// priority) picks at most one read per cycle; a tag pipeline running alongside
// the RAM routes each returned word back to the channel that issued it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wea/addra/dina    write port, never stalled
//   rd_req[NCH]       per-channel read request, held until granted
//   rd_addr[NCH*AW]   packed read addresses, channel i at [i*AW +: AW]
//   rd_gnt[NCH]       combinational one-hot (or zero) grant
//   rd_vld[NCH]       return-data valid, RD_LAT cycles after the grant
//   rd_data[NCH*DW]   packed return data, non-valid slices read 0
// -----------------------------------------------------------------------------
module mem_arb_rd_wrap
  import mem_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 16,
  parameter int NCH      = 4,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic [AW-1:0]     addra,
  input  logic [DW-1:0]     dina,
  input  logic [NCH-1:0]    rd_req,
  input  logic [NCH*AW-1:0] rd_addr,
  output logic [NCH-1:0]    rd_gnt,
  output logic [NCH-1:0]    rd_vld,
  output logic [NCH*DW-1:0] rd_data
);

  localparam int CW = ch_idx_w(NCH);

  logic [CW-1:0] ptr;
  logic [CW-1:0] scan_idx;
  logic          gnt_any;
  logic [CW-1:0] gnt_idx;
  logic [AW-1:0] rd_addr_sel;
  logic [DW-1:0] ram_dout;
  rd_tag_t       tag_pipe [RD_LAT];
  rd_tag_t       tag_out;

  // Arbiter. Both scans run from lowest to highest priority so the last hit
  // written is the winner. The grant never looks at rd_addr.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (ARB_MODE == ARB_FIXED || NCH == 1) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (rd_req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = CW'(i);
        end
      end
    end else begin
      // Priority order is ptr, ptr+1, ... mod NCH.
      for (int k = NCH - 1; k >= 0; k--) begin
        scan_idx = CW'((int'(ptr) + k) % NCH);
        if (rd_req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  // One-hot grant and the address of the granted channel.
  always_comb begin
    rd_gnt      = '0;
    rd_addr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_any && gnt_idx == CW'(i)) begin
        rd_gnt[i]   = 1'b1;
        rd_addr_sel = rd_addr[i*AW +: AW];
      end
    end
  end

  // Round-robin pointer: one past the last winner, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any && ARB_MODE == ARB_RR) begin
      ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
    end
  end

  sdp_ram #(
    .DW     (DW),
    .AW     (AW),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (gnt_any),
    .addrb (rd_addr_sel),
    .doutb (ram_dout)
  );

  // Tag pipeline, same depth as the RAM read latency. Reset drops in-flight
  // reads so their data is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: gnt_any, ch: MAX_CH_W'(gnt_idx)};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[RD_LAT-1];

  // Output demux: only the tagged channel sees the RAM word.
  always_comb begin
    rd_vld  = '0;
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tag_out.vld && tag_out.ch == MAX_CH_W'(i)) begin
        rd_vld[i]            = 1'b1;
        rd_data[i*DW +: DW]  = ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb_rd_wrap.sv
// -----------------------------------------------------------------------------
// tb_mem_arb_rd_wrap
// Two instances share the write/reset stimulus: dut 0 is round-robin with
// read latency 1, dut 1 is fixed priority with read latency 2. Each has its
// own channel request state. The driver predicts grants and return words from
// a plain reference model and queues expected returns; a monitor on the
// falling edge compares every cycle's rd_vld/rd_data against the queue head.
// -----------------------------------------------------------------------------
module tb_mem_arb_rd_wrap;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wea = 1'b0;
  logic [AW-1:0]     addra = '0;
  logic [DW-1:0]     dina = '0;
  logic [NCH-1:0]    rd_req  [2];
  logic [NCH*AW-1:0] rd_addr [2];
  logic [NCH-1:0]    rd_gnt  [2];
  logic [NCH-1:0]    rd_vld  [2];
  logic [NCH*DW-1:0] rd_data [2];

  mem_arb_rd_wrap #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(1), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]),
    .rd_gnt(rd_gnt[0]), .rd_vld(rd_vld[0]), .rd_data(rd_data[0])
  );

  mem_arb_rd_wrap #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(2), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]),
    .rd_gnt(rd_gnt[1]), .rd_vld(rd_vld[1]), .rd_data(rd_data[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            due;
    int            ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bit            pend  [2][NCH];
  logic [AW-1:0] paddr [2][NCH];
  int            mptr  [2];
  logic [DW-1:0] mmem  [int];
  logic [NCH-1:0] g_act [2];
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Reference arbitration: lowest index wins, or first requester from ptr.
  function automatic int model_grant(input logic [NCH-1:0] req, input int ptr, input bit fixed_mode);
    logic [NCH-1:0] sh;
    if (fixed_mode) begin
      for (int i = 0; i < NCH; i++) begin
        sh = req >> i;
        if (sh[0]) return i;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        sh = req >> ((ptr + k) % NCH);
        if (sh[0]) return (ptr + k) % NCH;
      end
    end
    return -1;
  endfunction

  // One clock cycle: drive, check the grant, update the model.
  task automatic do_cycle(input bit r, input bit we, input int wa, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    rst   = r;
    wea   = we;
    addra = AW'(wa);
    dina  = wd;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        rd_req[d][c]            = pend[d][c];
        rd_addr[d][c*AW +: AW]  = paddr[d][c];
      end
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      logic [NCH-1:0] req_v;
      logic [NCH-1:0] eg;
      int             g;
      exp_t           e;
      for (int c = 0; c < NCH; c++) req_v[c] = pend[d][c];
      g  = r ? -1 : model_grant(req_v, mptr[d], d == 1);
      eg = '0;
      if (g >= 0) eg = NCH'(1) << g;
      g_act[d] = rd_gnt[d];
      check($sformatf("gnt dut%0d", d), 32'(rd_gnt[d]), 32'(eg));
      if (g >= 0) begin
        e.due  = cyc + lat_of(d);
        e.ch   = g;
        e.data = mmem[int'(paddr[d][g])];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        pend[d][g] = 1'b0;
        if (d == 0) mptr[d] = (g + 1) % NCH;
      end
      if (r) begin
        mptr[d] = 0;
        if (d == 0) begin
          while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
        end else begin
          while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
        end
      end
    end
    if (we) mmem[wa] = wd;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      bit any;
      any = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NCH; c++) any |= pend[d][c];
      if (!any) break;
      do_cycle(1'b0, 1'b0, 0, '0);
    end
  endtask

  task automatic req_both(input int c, input int a);
    for (int d = 0; d < 2; d++) begin
      pend[d][c]  = 1'b1;
      paddr[d][c] = AW'(a);
    end
  endtask

  // Monitor: every cycle each instance either presents the queue head or
  // nothing at all.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          logic [NCH-1:0]    ev;
          logic [NCH*DW-1:0] ed;
          exp_t              e;
          bit                hit;
          ev  = '0;
          ed  = '0;
          hit = 1'b0;
          if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
          if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
          if (hit) begin
            ev = NCH'(1) << e.ch;
            ed = (NCH*DW)'(e.data) << (e.ch * DW);
          end
          check($sformatf("vld dut%0d", d), 32'(rd_vld[d]), 32'(ev));
          check($sformatf("data dut%0d", d), 32'(rd_data[d]), 32'(ed));
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_req[d]  = '0;
      rd_addr[d] = '0;
      mptr[d]    = 0;
      for (int c = 0; c < NCH; c++) begin
        pend[d][c]  = 1'b0;
        paddr[d][c] = '0;
      end
    end

    do_cycle(1'b1, 1'b0, 0, '0);
    do_cycle(1'b1, 1'b0, 0, '0);
    mon_en = 1'b1;

    // Initialise every address the bench will read.
    for (int a = 0; a < 32; a++) do_cycle(1'b0, 1'b1, a, DW'($urandom));
    for (int c = 0; c < NCH; c++) do_cycle(1'b0, 1'b1, 'h100 + c, DW'(8'h11 * (c + 1)));
    do_cycle(1'b0, 1'b1, 'h10, 8'hA5);
    do_cycle(1'b0, 1'b1, 'h20, 8'h3C);

    // Single read on channel 2.
    req_both(2, 'h10);
    do_cycle(1'b0, 1'b0, 0, '0);
    check("single rd gnt rr", 32'(g_act[0]), 32'h4);
    check("single rd gnt fx", 32'(g_act[1]), 32'h4);
    drain();

    // Same-cycle write and read: old data, then new data next cycle.
    req_both(2, 'h10);
    do_cycle(1'b0, 1'b1, 'h10, 8'h77);
    req_both(2, 'h10);
    do_cycle(1'b0, 1'b0, 0, '0);
    drain();

    // All channels requesting continuously from a fresh pointer.
    do_cycle(1'b1, 1'b0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NCH; c++) req_both(c, 'h100 + c);
      do_cycle(1'b0, 1'b0, 0, '0);
      check("rr sequence", 32'(g_act[0]), 32'(1 << (i % NCH)));
      check("fixed sequence", 32'(g_act[1]), 32'h1);
    end
    for (int d = 0; d < 2; d++) pend[d][0] = 1'b0;
    do_cycle(1'b0, 1'b0, 0, '0);
    check("fixed after ch0 drop", 32'(g_act[1]), 32'h2);
    drain();

    // Reset with a read in flight; pointer restarts at 0.
    req_both(1, 5);
    do_cycle(1'b0, 1'b0, 0, '0);
    req_both(3, 6);
    do_cycle(1'b1, 1'b0, 0, '0);
    check("gnt in rst rr", 32'(g_act[0]), 32'h0);
    check("gnt in rst fx", 32'(g_act[1]), 32'h0);
    req_both(0, 7);
    do_cycle(1'b0, 1'b0, 0, '0);
    check("ptr after rst", 32'(g_act[0]), 32'h1);
    drain();

    // Pointer wrap from channel 3 back to channel 0.
    req_both(3, 8);
    do_cycle(1'b0, 1'b0, 0, '0);
    drain();
    req_both(0, 9);
    req_both(2, 10);
    do_cycle(1'b0, 1'b0, 0, '0);
    check("rr wrap", 32'(g_act[0]), 32'h1);
    drain();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      bit r;
      r = ($urandom_range(0, 99) < 2);
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          if (!pend[d][c] && $urandom_range(0, 1) == 1) begin
            pend[d][c]  = 1'b1;
            paddr[d][c] = AW'($urandom_range(0, 31));
          end
        end
      end
      do_cycle(r, 1'($urandom_range(0, 1)), $urandom_range(0, 31), DW'($urandom));
    end

    drain();
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arb_rd_wrap.md
# mem_arb_rd_wrap

Parametrised successor to the two-reader memory wrapper. It puts `NCH` independent read channels and one write port on a single simple-dual-port RAM. Read requests go through a registered-pointer arbiter: round-robin or fixed-priority. Every returned word is routed to the channel that issued it, including when several channels request in the same cycle. It sits between the filter line-buffer/window readers and frame storage in the 5x5 Gaussian datapath.

## Interface
Parameters:
- `DW`, 8: data width in bits
- `AW`, 16: address width; RAM depth is 2**AW words
- `NCH`, 4: number of read channels, 1..16
- `RD_LAT`, 1: RAM read latency in cycles, 1 or 2
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- `clk`  in  1  single clock for all logic and both RAM ports
- `rst`  in  1  synchronous, active-high reset
- `wea`  in  1  write enable
- `addra`  in  AW  write address
- `dina`  in  DW  write data
- `rd_req`  in  NCH  per-channel read request (bit i = channel i)
- `rd_addr`  in  NCH*AW  packed read addresses; channel i at [i*AW +: AW]
- `rd_gnt`  out  NCH  one-hot or zero; combinational grant for the current cycle
- `rd_vld`  out  NCH  per-channel return-data valid, registered
- `rd_data`  out  NCH*DW  packed return data; channel i at [i*DW +: DW]

## Operation
- Handshake:
  - Channel i asserts `rd_req[i]` and holds `rd_addr[i]` stable until it sees `rd_gnt[i]` high at a clock edge.
  - The read is issued on that edge.
  - The channel may issue a new request in the next cycle.
- Grant: at most one bit of `rd_gnt` is high per cycle. `rd_gnt` is zero when `rd_req` is zero. The grant depends only on `rd_req` and the pointer, never on `rd_addr`.
- Round-robin (`ARB_MODE`=0):
  - Pointer `ptr` (width clog2(NCH)) resets to 0.
  - The granted channel is the first requester found scanning ptr, ptr+1, … mod NCH.
  - After a grant to channel g, `ptr` becomes (g+1) mod NCH. It wraps from NCH-1 to 0.
  - `ptr` holds when there is no grant.
- Fixed priority (`ARB_MODE`=1): the lowest-index requester wins and `ptr` is unused. Starvation of higher indices is allowed.
- Routing: each granted read pushes a tag {valid, channel index} into an RD_LAT-deep shift pipeline that runs alongside the RAM.
  - When the tag emerges, exactly one `rd_vld` bit is set, for that channel, and that channel's `rd_data` slice is loaded with the RAM output.
  - Non-valid slices read as 0.
- Write port:
  - Writes are never stalled or arbitrated.
  - A same-cycle read and write to the same address returns the old data (read-first).
- `NCH`=1: the arbiter degenerates to `rd_gnt = rd_req`.

## Timing
- Reset values: `rd_vld` = 0, `rd_data` = 0, `ptr` = 0, tag pipeline all invalid. `rd_gnt` follows `rd_req`, so it is 0 while requests are 0.
- Reset also applies to RAM contents? No. RAM contents are unaffected by `rst`.
- Read latency: a grant in cycle t gives `rd_vld[i]` high in cycle t+RD_LAT, for exactly one cycle per grant.
- Throughput: one read per cycle across all channels. Back-to-back grants give back-to-back valids in grant order.
- Reset mid-operation: in-flight tags are cleared, so no `rd_vld` appears for reads granted before `rst`. `ptr` returns to 0.
- Grant while `rst` is high: `rd_gnt` is forced to 0.
- Write visibility: a write in cycle t is visible to a read granted in cycle t+1 or later.

## Structure
- Shared package `mem_arb_pkg`:
  - `ARB_RR` = 0 and `ARB_FIXED` = 1 constants
  - `clog2`-based `CH_IDX_W` helper function
  - tag struct {vld, ch}
- Sub-module `sdp_ram`:
  - inferred simple-dual-port RAM, read-first, with `DW`, `AW`, `RD_LAT` parameters
  - replaces the vendor IP so depth and width scale
- The arbiter stays inline. The wrapper holds the arbiter, tag pipeline and output demux.

## Test plan
Defaults: NCH=4, DW=8, AW=16, RD_LAT=1, unless stated otherwise.
- Write 0xA5→0x0010 and 0x3C→0x0020, then single read on ch2 at 0x0010 → `rd_gnt`=4'b0100 in cycle t. In cycle t+1, `rd_vld`=4'b0100 and ch2 data = 0xA5; all other slices 0.
- All four channels request continuously at distinct addresses holding 0x11..0x44, RR mode → grants 0,1,2,3,0,… on consecutive cycles. Each channel gets its own value one cycle after its grant.
- Same stimulus with ARB_MODE=1 → ch0 is granted every cycle. Ch1..3 receive no grant until ch0 drops its request, then ch1 is granted.
- Write 0x77 and read of the same address in the same cycle (old value 0xA5) → read returns 0xA5. A read granted in the next cycle returns 0x77.
- Grant in cycle t, `rst` high in cycle t+1 (RD_LAT=2) → no `rd_vld` in t+2, and `ptr` restarts at 0 on the next request.
- Pointer wrap: last grant to ch3, then requests from ch0 and ch2 → ch0 is granted first.
